issue_scoreboard: RTL and testbench

- Issue controller between the instruction decoder and the execute stage.
- Classifies each decoded opcode and tracks pending register writes in a 16-entry scoreboard.
- Stalls decode on RAW/WAW hazards, on in-flight limit and on unresolved branches.
- Emits a registered issue strobe and a one-cycle flush on a taken branch.

---
 rtl/issue_pkg.sv | 11 +
 rtl/opcode_classifier.sv | 23 ++
 rtl/issue_scoreboard.sv | 93 +++++++++
 tb/tb_issue_scoreboard.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// issue_pkg: opcode constants, opcode classes and issue FSM states shared by the issue controller.
package issue_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b01101;
  localparam logic [4:0] OP_LDR  = 5'b10010;
  localparam logic [4:0] OP_STR  = 5'b10011;
  localparam logic [4:0] OP_B    = 5'b10100;
  typedef enum logic [2:0] {CLS_ALU_RR, CLS_ALU_IMM, CLS_LDR, CLS_STR, CLS_BR, CLS_NOP} op_class_t;
  typedef enum logic {RUN, BR_WAIT} state_t;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: decodes an opcode into its class and register read/write usage.
module opcode_classifier
  import issue_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  cls,
  output logic       uses_rn,
  output logic       uses_rm,
  output logic       reads_rd,
  output logic       writes_rd,
  output logic       is_branch
);
  assign cls = opcode[4:3] == 2'b00 ? CLS_ALU_RR :
               opcode[4:3] == 2'b01 ? CLS_ALU_IMM :
               opcode == OP_LDR     ? CLS_LDR :
               opcode == OP_STR     ? CLS_STR :
               opcode == OP_B       ? CLS_BR : CLS_NOP;
  assign uses_rn   = cls inside {CLS_ALU_RR, CLS_ALU_IMM, CLS_LDR, CLS_STR};
  assign uses_rm   = cls == CLS_ALU_RR;
  assign reads_rd  = cls == CLS_STR;
  assign writes_rd = cls inside {CLS_ALU_RR, CLS_ALU_IMM, CLS_LDR};
  assign is_branch = cls == CLS_BR;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: hazard-checking issue stage with a 16-entry write scoreboard and branch wait.
// Define ISSUE_FWD_EN to track only loads (ALU results forwarded) and ignore unmatched writebacks.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_opcode,
  input  logic [3:0]       dec_rn,
  input  logic [3:0]       dec_rm,
  input  logic [3:0]       dec_rd,
  output logic             iss_valid,
  output logic [4:0]       iss_opcode,
  output logic [3:0]       iss_rn,
  output logic [3:0]       iss_rm,
  output logic [3:0]       iss_rd,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);
  localparam logic [3:0] MAX_I = 4'(MAX_INFLIGHT);
  op_class_t  cls;
  state_t     state, state_n;
  logic       uses_rn, uses_rm, reads_rd, writes_rd, is_branch;
  logic [15:0] sb, sb_n, busy_vec, clr_mask, set_mask;
  logic [3:0] inflight;
  logic       tracked, wb_clr, hazard, full, accept, err_hit;
  opcode_classifier u_cls (
    .opcode(dec_opcode), .cls(cls), .uses_rn(uses_rn), .uses_rm(uses_rm),
    .reads_rd(reads_rd), .writes_rd(writes_rd), .is_branch(is_branch)
  );
`ifdef ISSUE_FWD_EN
  assign tracked = cls == CLS_LDR;
  assign err_hit = ex_br_valid && state == RUN;
`else
  assign tracked = cls inside {CLS_ALU_RR, CLS_ALU_IMM, CLS_LDR};
  assign err_hit = (ex_br_valid && state == RUN) || (wb_valid && !sb[wb_rd]);
`endif
  // A same-cycle writeback releases its register before hazards are evaluated.
  assign wb_clr   = wb_valid && sb[wb_rd];
  assign clr_mask = wb_clr ? 16'b1 << wb_rd : 16'b0;
  assign busy_vec = sb & ~clr_mask;
  assign hazard   = (uses_rn && busy_vec[dec_rn]) || (uses_rm && busy_vec[dec_rm]) ||
                    ((reads_rd || writes_rd) && busy_vec[dec_rd]);
  assign full     = tracked && inflight == MAX_I && !wb_clr;
  assign accept   = dec_valid && dec_ready;
  assign set_mask = accept && tracked ? 16'b1 << dec_rd : 16'b0;
  assign sb_n     = (sb & ~clr_mask) | set_mask;
  always_comb begin
    state_n = state == RUN ? (accept && is_branch ? BR_WAIT : RUN) : (ex_br_valid ? RUN : BR_WAIT);
  end
  always_comb begin
    dec_ready = state == RUN && !hazard && !full;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      sb         <= '0;
      inflight   <= '0;
      iss_valid  <= 1'b0;
      iss_opcode <= '0;
      iss_rn     <= '0;
      iss_rm     <= '0;
      iss_rd     <= '0;
      flush      <= 1'b0;
      stall_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      state     <= state_n;
      sb        <= sb_n;
      inflight  <= inflight + 4'(|set_mask) - 4'(wb_clr);
      iss_valid <= accept;
      if (accept) begin
        iss_opcode <= dec_opcode;
        iss_rn     <= dec_rn;
        iss_rm     <= dec_rm;
        iss_rd     <= dec_rd;
      end
      flush     <= state == BR_WAIT && ex_br_valid && ex_br_taken;
      stall_cnt <= dec_valid && !dec_ready && !(&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
      err       <= err | err_hit;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed and random stimulus checked against a register-level reference model.
module tb_issue_scoreboard;
  import issue_pkg::*;
  localparam int MAXI = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid = 1'b0, dec_ready;
  logic [4:0] dec_opcode = '0, iss_opcode;
  logic [3:0] dec_rn = '0, dec_rm = '0, dec_rd = '0, iss_rn, iss_rm, iss_rd;
  logic iss_valid, wb_valid = 1'b0, ex_br_valid = 1'b0, ex_br_taken = 1'b0, flush, err;
  logic [3:0] wb_rd = '0;
  logic [15:0] stall_cnt;
  int n_checks = 0, n_errors = 0;
  bit m_sb[16];
  bit m_wait, m_iss_v, m_flush, m_err;
  logic [16:0] m_fields;
  int m_stall;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rd(dec_rd),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_rn(iss_rn), .iss_rm(iss_rm),
    .iss_rd(iss_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .ex_br_valid(ex_br_valid),
    .ex_br_taken(ex_br_taken), .flush(flush), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void classify(input logic [4:0] op, output bit rn, output bit rm,
                                   output bit rdr, output bit wr, output bit trk, output bit br);
    int v = int'(op);
    rn  = v < 16 || v == 18 || v == 19;
    rm  = v < 8;
    rdr = v == 19;
    wr  = v < 16 || v == 18;
    br  = v == 20;
`ifdef ISSUE_FWD_EN
    trk = v == 18;
`else
    trk = wr;
`endif
  endfunction

  function automatic bit busy(input logic [3:0] r);
    return m_sb[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic int pending();
    int n = 0;
    foreach (m_sb[i]) n += int'(m_sb[i]);
    return n;
  endfunction

  task automatic cycle();
    bit rn, rm, rdr, wr, trk, br, ready, acc, wbclr;
    classify(dec_opcode, rn, rm, rdr, wr, trk, br);
    wbclr = wb_valid && m_sb[wb_rd];
    ready = !m_wait && !(rn && busy(dec_rn)) && !(rm && busy(dec_rm)) &&
            !((rdr || wr) && busy(dec_rd)) && !(trk && pending() == MAXI && !wbclr);
    #1 check("dec_ready", 32'(dec_ready), 32'(ready));
    acc = dec_valid && ready;
    if (rst) begin
      foreach (m_sb[i]) m_sb[i] = 1'b0;
      {m_wait, m_iss_v, m_flush, m_err, m_fields, m_stall} = '0;
    end else begin
      if (dec_valid && !ready && m_stall < 65535) m_stall++;
      if (ex_br_valid && !m_wait) m_err = 1'b1;
`ifndef ISSUE_FWD_EN
      if (wb_valid && !m_sb[wb_rd]) m_err = 1'b1;
`endif
      m_flush = m_wait && ex_br_valid && ex_br_taken;
      m_iss_v = acc;
      if (acc) m_fields = {dec_opcode, dec_rn, dec_rm, dec_rd};
      if (wbclr) m_sb[wb_rd] = 1'b0;
      if (acc && trk) m_sb[dec_rd] = 1'b1;
      m_wait = m_wait ? !ex_br_valid : acc && br;
    end
    @(posedge clk);
    #1;
    check("iss_valid", 32'(iss_valid), 32'(m_iss_v));
    check("iss_fields", 32'({iss_opcode, iss_rn, iss_rm, iss_rd}), 32'(m_fields));
    check("flush", 32'(flush), 32'(m_flush));
    check("err", 32'(err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic drv(input bit v, input logic [4:0] op, input logic [3:0] rn, input logic [3:0] rm,
                     input logic [3:0] rd, input bit wv = 0, input logic [3:0] wr = 0,
                     input bit bv = 0, input bit bt = 0);
    rst = 1'b0;
    {dec_valid, dec_opcode, dec_rn, dec_rm, dec_rd} = {v, op, rn, rm, rd};
    {wb_valid, wb_rd, ex_br_valid, ex_br_taken} = {wv, wr, bv, bt};
  endtask

  task automatic do_reset();
    drv(0, OP_ADD, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_iss_valid", 32'(iss_valid), 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    // RAW on ADD result, released by a same-cycle writeback
    drv(1, OP_ADD, 1, 2, 3); cycle();
    drv(1, OP_SUB, 3, 1, 6); cycle(); cycle();
    drv(1, OP_SUB, 3, 1, 6, 1, 3); cycle();
    drv(0, OP_ADD, 0, 0, 0); cycle();
    check("sub_iss_rd", 32'(iss_rd), 32'd6);
    // load then dependent store
    do_reset();
    drv(1, OP_LDR, 3, 0, 4); cycle();
    drv(1, OP_STR, 3, 0, 4); cycle(); cycle();
    drv(1, OP_STR, 3, 0, 4, 1, 4); cycle();
    drv(0, OP_ADD, 0, 0, 0); cycle();
    // in-flight limit
    do_reset();
    for (int i = 1; i <= 4; i++) begin drv(1, OP_ADDI, 0, 0, 4'(i)); cycle(); end
    drv(1, OP_ADDI, 0, 0, 5); cycle(); cycle();
    drv(1, OP_ADDI, 0, 0, 5, 1, 2); cycle();
    drv(0, OP_ADD, 0, 0, 0); cycle();
    // taken and not-taken branches
    for (int t = 1; t >= 0; t--) begin
      do_reset();
      drv(1, OP_B, 0, 0, 0); cycle();
      drv(1, OP_ADD, 1, 2, 3); cycle(); cycle(); cycle();
      drv(1, OP_ADD, 1, 2, 3, 0, 0, 1, t[0]); cycle();
      check("flush_pulse", 32'(flush), 32'(t));
      drv(0, OP_ADD, 0, 0, 0); cycle();
      check("flush_drop", 32'(flush), 32'd0);
    end
    // protocol errors and reset in branch wait
    do_reset();
    drv(0, OP_ADD, 0, 0, 0, 1, 9); cycle();
    drv(0, OP_ADD, 0, 0, 0); cycle(); cycle();
    do_reset();
    drv(0, OP_ADD, 0, 0, 0, 0, 0, 1, 1); cycle();
    check("err_br_in_run", 32'(err), 32'd1);
    do_reset();
    drv(1, OP_LDR, 1, 0, 2); cycle();
    drv(1, OP_B, 0, 0, 0); cycle();
    drv(1, OP_ADD, 0, 0, 0); cycle();
    rst = 1'b1; cycle();
    check("rst_brwait_valid", 32'(iss_valid), 32'd0);
    drv(1, OP_ADD, 2, 0, 3); cycle();
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 5)),
          4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), $urandom_range(0, 2) == 0,
          4'($urandom_range(0, 5)), $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      rst = $urandom_range(0, 199) == 0;
      cycle();
    end
    // stall counter saturation while parked in branch wait
    do_reset();
    drv(1, OP_B, 0, 0, 0); cycle();
    drv(1, OP_ADD, 1, 2, 3);
    for (int i = 0; i < 70000; i++) cycle();
    check("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
